wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Write-back arbiter and scoreboard that drives the register file's single write port (we/waddr/wdata) from two producers.
  - ALU path: single-cycle, never back-pressured.
  - Long-latency path: LSU/MUL with valid/ready handshake, buffered in a small FIFO.
- Tracks destination registers with outstanding long-latency writes.
- Gives the decode stage busy flags so it can stall operand reads and WAW issue.

Parameters:
- MXLEN, 64, data width of a register (matches `MXLEN).
- DEPTH, 4, long-latency FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result valid this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  MXLEN  ALU result
- lsu_valid  in  1  long-latency result offered
- lsu_ready  out  1  FIFO can accept
- lsu_rd  in  5  long-latency destination
- lsu_data  in  MXLEN  long-latency result
- issue_valid  in  1  decode issuing a long-latency op
- issue_rd  in  5  its destination
- issue_ready  out  1  issue accepted (rd not already pending)
- qaddr1  in  5  source address 1 to check
- qaddr2  in  5  source address 2 to check
- busy1  out  1  qaddr1 has a pending long write
- busy2  out  1  qaddr2 has a pending long write
- we  out  1  register-file write enable
- waddr  out  5  register-file write address
- wdata  out  MXLEN  register-file write data

Behaviour:
- Reset values while rst=1 (async assert, sync deassert into logic):
  - we=0, waddr=0, wdata=0.
  - FIFO empty; lsu_ready=1.
  - All pending bits 0; busy1=busy2=0; issue_ready=1.
- Write port is registered: a source selected in cycle N appears on we/waddr/wdata in cycle N+1.
- Each cycle the port is held for exactly one cycle per write; we=0 otherwise.
- Arbitration: the ALU has absolute priority.
  - If alu_valid=1 and alu_rd!=0: the ALU result is written next cycle.
  - Else if the FIFO is non-empty: the head entry pops and is written next cycle.
  - Else: we=0 next cycle.
- x0 handling:
  - An ALU result to x0 is discarded and does not block the FIFO pop that cycle.
  - A long result to x0 is accepted (handshake completes) but is not pushed.
  - x0 is never marked pending.
- FIFO behaviour:
  - Push when lsu_valid && lsu_ready.
  - lsu_ready = !full, using registered full; no push while full even if a pop occurs that cycle.
  - Push and pop in the same cycle (not full) leaves the occupancy unchanged.
  - Read and write pointers wrap modulo DEPTH; occupancy counter width is log2(DEPTH)+1.
- Scoreboard: 31-bit pending vector, one bit per x1..x31.
  - issue_ready = !pending[issue_rd] || issue_rd==0.
  - Set: issue_valid && issue_ready && issue_rd!=0 sets pending[issue_rd] at the clock edge.
  - Clear: pending[rd] clears on the edge where a FIFO entry for rd is popped to the write port.
  - Set and clear of the same rd in one cycle cannot occur, because issue is blocked while pending.
  - Set and clear of different regs in one cycle both take effect.
- busy flags:
  - busyN is combinational: pending[qaddrN], or 0 when qaddrN==0.
  - The pending bit is still 1 in the cycle the popped value sits on the write port; the register file's own write-through covers that cycle.
- Protocol contract on the producers: decode must not let an ALU op write a register whose pending bit is set (WAW). If it does, both writes occur in arbitration order; no error is flagged.
- Mid-operation reset: FIFO contents and pending bits are dropped immediately; any in-flight write is not performed.

Optional Feature:
- Macro: WB_FWD_EN.
- When defined, four extra outputs are added:
  - fwd_hit1, fwd_data1 (MXLEN), fwd_hit2, fwd_data2 (MXLEN).
  - fwd_hitN=1 when a valid FIFO entry has rd==qaddrN (qaddrN!=0); fwd_dataN is that entry's data.
  - When several entries match, the youngest wins.
  - When fwd_hitN=1, busyN is forced to 0.
- When not defined: the ports are absent, and busyN stays set until the write commits.

Test Plan:
- Reset, then ALU alu_rd=5, alu_data=0x1234 for one cycle -> next cycle we=1, waddr=5, wdata=0x1234; the cycle after, we=0.
- Issue rd=7, then lsu result rd=7 data=0xABCD with ALU idle:
  - busy1=1 while qaddr1=7.
  - Write appears 2 cycles after the lsu handshake.
  - pending[7] clears on that edge.
- ALU valid every cycle for 6 cycles while pushing 5 lsu results with DEPTH=4:
  - lsu_ready drops to 0 after the 4th push.
  - The FIFO drains only after the ALU stops, in FIFO order.
- issue_rd=9 twice back-to-back -> the second has issue_ready=0 until the rd=9 long write commits.
- ALU alu_rd=0 and lsu result rd=0 -> no write issued, lsu handshake completes, no pending bit set.
- Assert rst with 3 FIFO entries and 3 pending regs -> we=0 immediately, lsu_ready=1, busy flags 0, no writes after release.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Write-back arbiter for the register-file write port. The ALU has
//            priority over a buffered long-latency (LSU/MUL) path. Also keeps a
//            pending-write scoreboard that drives the decode busy flags.
// Options  : WB_FWD_EN adds FIFO-to-decode forwarding outputs.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int MXLEN = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [MXLEN-1:0] alu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [4:0]       lsu_rd,
    input  logic [MXLEN-1:0] lsu_data,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    output logic             issue_ready,
    input  logic [4:0]       qaddr1,
    input  logic [4:0]       qaddr2,
    output logic             busy1,
    output logic             busy2,
    output logic             we,
    output logic [4:0]       waddr,
    output logic [MXLEN-1:0] wdata
`ifdef WB_FWD_EN
    ,
    output logic             fwd_hit1,
    output logic [MXLEN-1:0] fwd_data1,
    output logic             fwd_hit2,
    output logic [MXLEN-1:0] fwd_data2
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [MXLEN-1:0] fdata_q [DEPTH];
    logic [4:0]       frd_q   [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q, count_d;
    logic [31:1]      pend_q, pend_d, set_vec, clr_vec;
    logic [31:0]      pend_ext;
    logic             we_q, wlong_q;
    logic [4:0]       waddr_q;
    logic [MXLEN-1:0] wdata_q;
    logic             full, alu_take, pop, push;

    assign full      = (count_q == FULL_CNT);
    assign lsu_ready = !full;
    assign alu_take  = alu_valid && (alu_rd != 5'd0);
    assign pop       = !alu_take && (count_q != '0);
    // x0 results complete the handshake but are never stored.
    assign push      = lsu_valid && !full && (lsu_rd != 5'd0);

    assign pend_ext    = {pend_q, 1'b0};
    assign issue_ready = !pend_ext[issue_rd];

    // A pending bit drops at the end of the cycle its long write is on the port.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int r = 1; r < 32; r++) begin
            set_vec[r] = issue_valid && issue_ready && (issue_rd == 5'(r));
            clr_vec[r] = wlong_q && (waddr_q == 5'(r));
        end
        pend_d = (pend_q & ~clr_vec) | set_vec;
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fdata_q[wptr_q] <= lsu_data;
            frd_q[wptr_q]   <= lsu_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
            we_q    <= 1'b0;
            wlong_q <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= '0;
        end else begin
            count_q <= count_d;
            pend_q  <= pend_d;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            we_q    <= alu_take || pop;
            wlong_q <= pop;
            if (alu_take) begin
                waddr_q <= alu_rd;
                wdata_q <= alu_data;
            end else if (pop) begin
                waddr_q <= frd_q[rptr_q];
                wdata_q <= fdata_q[rptr_q];
            end else begin
                waddr_q <= 5'd0;
                wdata_q <= '0;
            end
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

`ifdef WB_FWD_EN
    logic [AW-1:0] fidx;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        fidx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fidx = rptr_q + AW'(i);
            if ((AW+1)'(i) < count_q) begin
                if ((qaddr1 != 5'd0) && (frd_q[fidx] == qaddr1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = fdata_q[fidx];
                end
                if ((qaddr2 != 5'd0) && (frd_q[fidx] == qaddr2)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = fdata_q[fidx];
                end
            end
        end
    end

    assign busy1 = pend_ext[qaddr1] && !fwd_hit1;
    assign busy2 = pend_ext[qaddr2] && !fwd_hit2;
`else
    assign busy1 = pend_ext[qaddr1];
    assign busy2 = pend_ext[qaddr2];
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Brief    : Scoreboard bench for wb_arbiter against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int MXLEN = 64;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             alu_valid, lsu_valid, issue_valid;
    logic [4:0]       alu_rd, lsu_rd, issue_rd, qaddr1, qaddr2;
    logic [MXLEN-1:0] alu_data, lsu_data;
    logic             lsu_ready, issue_ready, busy1, busy2, we;
    logic [4:0]       waddr;
    logic [MXLEN-1:0] wdata;

    wb_arbiter #(.MXLEN(MXLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .qaddr1(qaddr1), .qaddr2(qaddr2), .busy1(busy1), .busy2(busy2),
        .we(we), .waddr(waddr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             we;
        logic [4:0]       a;
        logic [MXLEN-1:0] d;
    } wr_t;
    typedef struct {
        logic [4:0]       rd;
        logic [MXLEN-1:0] d;
    } ent_t;

    wr_t  exp_q[$];
    ent_t mfifo[$];
    bit   pend[32];
    bit   commit_v;
    int   commit_rd;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [MXLEN-1:0] act, input logic [MXLEN-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        mfifo.delete();
        exp_q.delete();
        foreach (pend[i]) pend[i] = 0;
        commit_v = 0;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = '0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = '0;
        issue_valid = 0; issue_rd = 0;
    endtask

    // One clock of stimulus: check combinational outputs, then predict the edge.
    task automatic cyc(input logic av, input logic [4:0] ard, input logic [MXLEN-1:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [MXLEN-1:0] ld,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] q1, input logic [4:0] q2);
        bit   e_lr, e_ir;
        wr_t  e;
        ent_t f;
        @(negedge clk);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        issue_valid = iv; issue_rd = ird; qaddr1 = q1; qaddr2 = q2;
        #1;
        e_lr = (mfifo.size() < DEPTH);
        e_ir = (ird == 0) || !pend[ird];
        chk("lsu_ready", {63'd0, lsu_ready}, {63'd0, e_lr});
        chk("issue_ready", {63'd0, issue_ready}, {63'd0, e_ir});
        chk("busy1", {63'd0, busy1}, {63'd0, (q1 != 0) && pend[q1]});
        chk("busy2", {63'd0, busy2}, {63'd0, (q2 != 0) && pend[q2]});
        if (commit_v) pend[commit_rd] = 0;
        if (iv && e_ir && ird != 0) pend[ird] = 1;
        commit_v = 0;
        if (av && ard != 0) begin
            e = '{we: 1'b1, a: ard, d: ad};
        end else if (mfifo.size() > 0) begin
            f = mfifo.pop_front();
            e = '{we: 1'b1, a: f.rd, d: f.d};
            commit_v  = 1;
            commit_rd = int'(f.rd);
        end else begin
            e = '{we: 1'b0, a: 5'd0, d: '0};
        end
        if (lv && e_lr && lrd != 0) mfifo.push_back('{rd: lrd, d: ld});
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [4:0] q1);
        repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, q1, 0);
    endtask

    // Monitor: one scoreboard entry per clock edge while out of reset.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("we", {63'd0, we}, {63'd0, e.we});
                    if (e.we) begin
                        chk("waddr", {59'd0, waddr}, {59'd0, e.a});
                        chk("wdata", wdata, e.d);
                    end
                end else begin
                    chk("we_idle", {63'd0, we}, 64'd0);
                end
            end
        end
    end

    task automatic do_reset(input logic [4:0] q1, input logic [4:0] q2);
        @(negedge clk);
        #2;
        rst = 1;
        idle_inputs();
        qaddr1 = q1; qaddr2 = q2; issue_rd = q1;
        #1;
        chk("rst_we", {63'd0, we}, 64'd0);
        chk("rst_waddr", {59'd0, waddr}, 64'd0);
        chk("rst_wdata", wdata, 64'd0);
        chk("rst_lsu_ready", {63'd0, lsu_ready}, 64'd1);
        chk("rst_issue_ready", {63'd0, issue_ready}, 64'd1);
        chk("rst_busy1", {63'd0, busy1}, 64'd0);
        chk("rst_busy2", {63'd0, busy2}, 64'd0);
        model_clear();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        qaddr1 = 0; qaddr2 = 0;
        model_clear();
        do_reset(0, 0);

        // ALU write to x5
        cyc(1, 5, 64'h1234, 0, 0, 0, 0, 0, 0, 0);
        idle(2, 0);

        // Long write to x7 with busy tracking
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        idle(1, 7);
        cyc(0, 0, 0, 1, 7, 64'hABCD, 0, 0, 7, 0);
        idle(4, 7);

        // ALU hogs the port while the FIFO fills past capacity
        for (int i = 0; i < 6; i++)
            cyc(1, 5'(20 + i), 64'(100 + i), (i < 5), 5'(1 + i), 64'(200 + i), 0, 0, 5'(1 + i), 0);
        idle(6, 0);

        // Back-to-back issue of x9
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        cyc(0, 0, 0, 1, 9, 64'h99, 1, 9, 9, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        idle(3, 9);

        // x0 results and x0 issue
        cyc(1, 0, 64'h55, 1, 0, 64'h66, 1, 0, 0, 0);
        idle(2, 0);

        // Three pending registers and three buffered entries, then reset
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1, 2);
        cyc(0, 0, 0, 0, 0, 0, 1, 2, 1, 2);
        cyc(0, 0, 0, 0, 0, 0, 1, 3, 1, 2);
        for (int i = 0; i < 3; i++)
            cyc(1, 10, 64'(300 + i), 1, 5'(1 + i), 64'(400 + i), 0, 0, 1, 2);
        do_reset(1, 2);
        idle(4, 1);

        // Randomized traffic
        for (int n = 0; n < 400; n++)
            cyc(($urandom % 3) == 0, 5'($urandom % 8), {$urandom, $urandom},
                ($urandom % 2) == 1, 5'($urandom % 8), {$urandom, $urandom},
                ($urandom % 3) == 0, 5'($urandom % 8),
                5'($urandom % 8), 5'($urandom % 8));
        idle(8, 0);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
